alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a power of two, >= 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 op  input  3  opcode: 000 add, 001 sub, 010 or, 011 and, 100 not, 101 comp, 110 shr, 111 shl.
REQ-007 in_A  input  WIDTH  operand A.
REQ-008 in_B  input  WIDTH  operand B; shift amount = in_B[SHW-1:0] for shr/shl.
REQ-009 out  output  WIDTH  registered result; holds between operations.
REQ-010 flags  output  4  registered flags: [0]=Z, [1]=N, [2]=C, [3]=V.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when out/flags have just been written.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, SHIFT, DONE; DONE lasts exactly one cycle, then IDLE unless a new start is accepted.
REQ-014 start=1 at edge k with busy=0 (IDLE or DONE) SHALL latch in_A, in_B, op; busy=1 after edge k.
REQ-015 start while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-016 Non-shift ops, and shifts with amount 0: EXEC->DONE; out/flags written at edge k+1; done=1, busy=0 during cycle after k+1.
REQ-017 Shift with amount n>0: SHIFT state, one bit per cycle; out/flags written at edge k+n; done pulses in cycle after k+n.
REQ-018 Start accepted in DONE cycle SHALL begin back-to-back; no idle cycle required.
REQ-019 add: {C,out} = A+B, WIDTH+1-bit sum; V = signed overflow.
REQ-020 sub: out = A-B modulo 2^WIDTH; C = 1 iff A<B unsigned (borrow); V = signed overflow.
REQ-021 or/and: bitwise A|B, A&B; not: ~A; C=0, V=0 for all three.
REQ-022 comp: flags computed as for sub; out SHALL retain its previous value.
REQ-023 shr logical (zero fill), shl zero fill; C = last bit shifted out; n=0 gives out=A, C=0; V=0.
REQ-024 Z = (result==0), N = result[WIDTH-1]; for comp, result is the A-B difference.
REQ-025 out/flags SHALL only change at the completion edge of an operation or on reset.

Reset
REQ-026 rst=1 at an edge SHALL force out=0, flags=0, busy=0, done=0, state IDLE.
REQ-027 rst SHALL take priority over start; start in a reset cycle is dropped.
REQ-028 rst mid-operation (EXEC or SHIFT) SHALL abort; no done pulse for the aborted op.

Verification
REQ-029 WIDTH=8, add A=0x03 B=0x11 -> after edge k+1: out=0x14, flags=0000, done one cycle, busy low.
REQ-030 add 0xFF+0x01 -> out=0x00, Z=1 C=1 N=0 V=0; then sub 0x80-0x01 -> out=0x7F, V=1 C=0 N=0 Z=0.
REQ-031 After REQ-030, comp A=0x05 B=0x07 -> out stays 0x7F, C=1 N=1 Z=0 V=0.
REQ-032 shl A=0x81 B=0x03 -> busy 3 cycles, out=0x08, C=0; shr A=0x81 B=0x01 -> out=0x40, C=1 after 1 cycle; shl B=0x00 -> out=A, C=0 after 1 cycle.
REQ-033 shl A=0x01 B=0x05; pulse start again mid-shift -> ignored; assert rst in 3rd shift cycle -> busy=0, no done, out=0x00, flags=0000.
REQ-034 WIDTH=16, add 0xFFFF+0x0001 -> out=0x0000, Z=1 C=1; shr 0x8000 by 15 -> out=0x0001, done after 15 cycles.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between an ALU client and alu_seq.
//   start          request strobe, sampled by the ALU only while busy=0
//   op             opcode (add/sub/or/and/not/comp/shr/shl)
//   in_A, in_B     operands; in_B low bits carry the shift amount
//   out, flags     registered result and flags {V,C,N,Z}
//   busy, done     operation in progress / one-cycle completion pulse
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [WIDTH-1:0] out;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output start, op, in_A, in_B,
        input  out, flags, busy, done
    );

    modport slave (
        input  start, op, in_A, in_B,
        output out, flags, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU. Arithmetic/logic ops finish one cycle after
// the request is accepted; shifts step one bit per cycle.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_seq_if slave: start/op/in_A/in_B in, out/flags/busy/done out
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_COMP = 3'b101;
    localparam logic [2:0] OP_SHR  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Single-cycle ALU over the latched operands; used from EXEC only
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] res_c;
    logic             car_c;
    logic             ovf_c;
    logic             keep_out_c;

    always_comb begin
        sum_c      = {1'b0, a_q} + {1'b0, b_q};
        // MSB of the extended difference is the unsigned borrow (A < B)
        diff_c     = {1'b0, a_q} - {1'b0, b_q};
        res_c      = a_q;
        car_c      = 1'b0;
        ovf_c      = 1'b0;
        keep_out_c = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_c = sum_c[WIDTH-1:0];
                car_c = sum_c[WIDTH];
                ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB, OP_COMP: begin
                res_c      = diff_c[WIDTH-1:0];
                car_c      = diff_c[WIDTH];
                ovf_c      = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_c[WIDTH-1] != a_q[WIDTH-1]);
                keep_out_c = (op_q == OP_COMP);
            end
            OP_OR:  res_c = a_q | b_q;
            OP_AND: res_c = a_q & b_q;
            OP_NOT: res_c = ~a_q;
            // Zero-amount shifts land here: result is A, no carry
            OP_SHR, OP_SHL: res_c = a_q;
            default: res_c = a_q;
        endcase
    end

    // One-bit shift step and the bit it pushes out
    logic [WIDTH-1:0] step_c;
    logic             step_out_c;

    always_comb begin
        if (op_q[0]) begin
            step_c     = {sh_q[WIDTH-2:0], 1'b0};
            step_out_c = sh_q[WIDTH-1];
        end else begin
            step_c     = {1'b0, sh_q[WIDTH-1:1]};
            step_out_c = sh_q[0];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        out_d   = out_q;
        flags_d = flags_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d    = bus.in_A;
                    b_d    = bus.in_B;
                    op_d   = bus.op;
                    cnt_d  = bus.in_B[SHW-1:0];
                    sh_d   = bus.in_A;
                    busy_d = 1'b1;
                    if (bus.op[2:1] == 2'b11 && bus.in_B[SHW-1:0] != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                out_d   = keep_out_c ? out_q : res_c;
                flags_d = {ovf_c, car_c, res_c[WIDTH-1], (res_c == '0)};
                done_d  = 1'b1;
                state_d = DONE;
            end
            SHIFT: begin
                sh_d   = step_c;
                cnt_d  = cnt_q - SHW'(1);
                busy_d = 1'b1;
                if (cnt_q == SHW'(1)) begin
                    out_d   = step_c;
                    flags_d = {1'b0, step_out_c, step_c[WIDTH-1], (step_c == '0)};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            out_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.flags = flags_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  b8();
    alu_seq_if #(.WIDTH(16)) b16();

    alu_seq #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
    alu_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(b16));

    // Issue one 8-bit op from a negedge; returns at the negedge where done is seen.
    // lat = number of rising edges after the accepting edge (-1 on timeout).
    task automatic do_op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic bsy_start);
        b8.start = 1'b1; b8.op = op; b8.in_A = a; b8.in_B = b;
        @(posedge clk); #1;
        bsy_start = b8.busy;
        b8.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b8.done) begin lat = i; break; end
        end
    endtask

    task automatic do_op16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           output int lat);
        b16.start = 1'b1; b16.op = op; b16.in_A = a; b16.in_B = b;
        @(posedge clk); #1;
        b16.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b16.done) begin lat = i; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        b8.start = 1'b1; b8.op = 3'b000; b8.in_A = 8'h01; b8.in_B = 8'h01;
        b16.start = 1'b0; b16.op = 3'b000; b16.in_A = '0; b16.in_B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; b8.start = 1'b0;
        total++;
        if ({b8.out, b8.flags, b8.busy, b8.done} !== 14'h0) begin
            bad++; $display("FAIL reset8 got out=%h flags=%b busy=%b done=%b want 0", b8.out, b8.flags, b8.busy, b8.done);
        end
        total++;
        if ({b16.out, b16.flags, b16.busy, b16.done} !== 22'h0) begin
            bad++; $display("FAIL reset16 got out=%h flags=%b busy=%b done=%b want 0", b16.out, b16.flags, b16.busy, b16.done);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin
            bad++; $display("FAIL reset_drops_start got busy=%b done=%b want 0 0", b8.busy, b8.done);
        end
    endtask

    task automatic test_add;
        int lat; logic bs;
        do_op8(3'b000, 8'h03, 8'h11, lat, bs);
        total++;
        if (lat !== 1 || bs !== 1'b1 || b8.busy !== 1'b0) begin
            bad++; $display("FAIL add_timing got lat=%0d busy_start=%b busy_done=%b want 1 1 0", lat, bs, b8.busy);
        end
        total++;
        if (b8.out !== 8'h14 || b8.flags !== 4'b0000) begin
            bad++; $display("FAIL add_result got out=%h flags=%b want 14 0000", b8.out, b8.flags);
        end
        @(negedge clk);
        total++;
        if (b8.done !== 1'b0 || b8.out !== 8'h14) begin
            bad++; $display("FAIL add_done_pulse got done=%b out=%h want 0 14", b8.done, b8.out);
        end
    endtask

    task automatic test_flags;
        int lat; logic bs;
        do_op8(3'b000, 8'hFF, 8'h01, lat, bs);
        total++;
        if (b8.out !== 8'h00 || b8.flags !== 4'b0101 || lat !== 1) begin
            bad++; $display("FAIL add_carry got out=%h flags=%b lat=%0d want 00 0101 1", b8.out, b8.flags, lat);
        end
        do_op8(3'b001, 8'h80, 8'h01, lat, bs);
        total++;
        if (b8.out !== 8'h7F || b8.flags !== 4'b1000) begin
            bad++; $display("FAIL sub_ovf got out=%h flags=%b want 7f 1000", b8.out, b8.flags);
        end
        do_op8(3'b101, 8'h05, 8'h07, lat, bs);
        total++;
        if (b8.out !== 8'h7F || b8.flags !== 4'b0110 || lat !== 1) begin
            bad++; $display("FAIL comp got out=%h flags=%b lat=%0d want 7f 0110 1", b8.out, b8.flags, lat);
        end
        do_op8(3'b000, 8'h7F, 8'h01, lat, bs);
        total++;
        if (b8.out !== 8'h80 || b8.flags !== 4'b1010) begin
            bad++; $display("FAIL add_ovf got out=%h flags=%b want 80 1010", b8.out, b8.flags);
        end
        do_op8(3'b010, 8'hA0, 8'h05, lat, bs);
        total++;
        if (b8.out !== 8'hA5 || b8.flags !== 4'b0010) begin
            bad++; $display("FAIL or got out=%h flags=%b want a5 0010", b8.out, b8.flags);
        end
        do_op8(3'b011, 8'hF0, 8'h0F, lat, bs);
        total++;
        if (b8.out !== 8'h00 || b8.flags !== 4'b0001) begin
            bad++; $display("FAIL and got out=%h flags=%b want 00 0001", b8.out, b8.flags);
        end
        do_op8(3'b100, 8'h0F, 8'hFF, lat, bs);
        total++;
        if (b8.out !== 8'hF0 || b8.flags !== 4'b0010) begin
            bad++; $display("FAIL not got out=%h flags=%b want f0 0010", b8.out, b8.flags);
        end
        do_op8(3'b001, 8'h10, 8'h20, lat, bs);
        total++;
        if (b8.out !== 8'hF0 || b8.flags !== 4'b0110) begin
            bad++; $display("FAIL sub_borrow got out=%h flags=%b want f0 0110", b8.out, b8.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_shift;
        int lat; logic bs;
        do_op8(3'b111, 8'h81, 8'h03, lat, bs);
        total++;
        if (b8.out !== 8'h08 || b8.flags !== 4'b0000 || lat !== 3) begin
            bad++; $display("FAIL shl3 got out=%h flags=%b lat=%0d want 08 0000 3", b8.out, b8.flags, lat);
        end
        do_op8(3'b110, 8'h81, 8'h01, lat, bs);
        total++;
        if (b8.out !== 8'h40 || b8.flags !== 4'b0100 || lat !== 1) begin
            bad++; $display("FAIL shr1 got out=%h flags=%b lat=%0d want 40 0100 1", b8.out, b8.flags, lat);
        end
        do_op8(3'b111, 8'h81, 8'h00, lat, bs);
        total++;
        if (b8.out !== 8'h81 || b8.flags !== 4'b0010 || lat !== 1) begin
            bad++; $display("FAIL shl0 got out=%h flags=%b lat=%0d want 81 0010 1", b8.out, b8.flags, lat);
        end
        // only in_B[2:0] is the amount: 0xF9 shifts by 1
        do_op8(3'b111, 8'h0F, 8'hF9, lat, bs);
        total++;
        if (b8.out !== 8'h1E || b8.flags !== 4'b0000 || lat !== 1) begin
            bad++; $display("FAIL shl_mask got out=%h flags=%b lat=%0d want 1e 0000 1", b8.out, b8.flags, lat);
        end
        do_op8(3'b110, 8'h01, 8'h01, lat, bs);
        total++;
        if (b8.out !== 8'h00 || b8.flags !== 4'b0101) begin
            bad++; $display("FAIL shr_zero got out=%h flags=%b want 00 0101", b8.out, b8.flags);
        end
        do_op8(3'b110, 8'h80, 8'h07, lat, bs);
        total++;
        if (b8.out !== 8'h01 || b8.flags !== 4'b0000 || lat !== 7) begin
            bad++; $display("FAIL shr7 got out=%h flags=%b lat=%0d want 01 0000 7", b8.out, b8.flags, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat; logic bs;
        do_op8(3'b000, 8'h01, 8'h02, lat, bs);
        // next request issued in the DONE cycle
        do_op8(3'b001, 8'h03, 8'h03, lat, bs);
        total++;
        if (bs !== 1'b1 || lat !== 1 || b8.out !== 8'h00 || b8.flags !== 4'b0001) begin
            bad++; $display("FAIL b2b_sub got busy_start=%b lat=%0d out=%h flags=%b want 1 1 00 0001", bs, lat, b8.out, b8.flags);
        end
        do_op8(3'b111, 8'h03, 8'h02, lat, bs);
        total++;
        if (bs !== 1'b1 || lat !== 2 || b8.out !== 8'h0C) begin
            bad++; $display("FAIL b2b_shl got busy_start=%b lat=%0d out=%h want 1 2 0c", bs, lat, b8.out);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore;
        int lat;
        b8.start = 1'b1; b8.op = 3'b111; b8.in_A = 8'h01; b8.in_B = 8'h04;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(negedge clk);
        b8.start = 1'b1; b8.op = 3'b000; b8.in_A = 8'hFF; b8.in_B = 8'h01;
        @(posedge clk); #1;
        b8.start = 1'b0;
        lat = -1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b8.done) begin lat = i; break; end
        end
        total++;
        if (lat !== 4 || b8.out !== 8'h10 || b8.flags !== 4'b0000) begin
            bad++; $display("FAIL ignore_busy got lat=%0d out=%h flags=%b want 4 10 0000", lat, b8.out, b8.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int seen_done;
        b8.start = 1'b1; b8.op = 3'b111; b8.in_A = 8'h01; b8.in_B = 8'h05;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(negedge clk);
        b8.start = 1'b1; b8.op = 3'b000; b8.in_A = 8'hAA; b8.in_B = 8'h55;
        @(posedge clk); #1;
        b8.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (b8.busy !== 1'b1 || b8.done !== 1'b0 || b8.out !== 8'h10) begin
            bad++; $display("FAIL abort_pre got busy=%b done=%b out=%h want 1 0 10", b8.busy, b8.done, b8.out);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.out !== 8'h00 || b8.flags !== 4'b0000) begin
            bad++; $display("FAIL abort_reset got busy=%b done=%b out=%h flags=%b want 0 0 00 0000", b8.busy, b8.done, b8.out, b8.flags);
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b8.done || b8.busy) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin
            bad++; $display("FAIL abort_no_done got active_cycles=%0d want 0", seen_done);
        end
    endtask

    task automatic test_wide;
        int lat;
        do_op16(3'b000, 16'hFFFF, 16'h0001, lat);
        total++;
        if (b16.out !== 16'h0000 || b16.flags !== 4'b0101 || lat !== 1) begin
            bad++; $display("FAIL w16_add got out=%h flags=%b lat=%0d want 0000 0101 1", b16.out, b16.flags, lat);
        end
        do_op16(3'b110, 16'h8000, 16'h000F, lat);
        total++;
        if (b16.out !== 16'h0001 || b16.flags !== 4'b0000 || lat !== 15) begin
            bad++; $display("FAIL w16_shr15 got out=%h flags=%b lat=%0d want 0001 0000 15", b16.out, b16.flags, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b8.start = 1'b0; b8.op = '0; b8.in_A = '0; b8.in_B = '0;
        b16.start = 1'b0; b16.op = '0; b16.in_A = '0; b16.in_B = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_flags();
        test_shift();
        test_back_to_back();
        test_ignore();
        test_abort();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
